// File: rtl/mem_dump_uart_pkg.sv
// Shared types and frame constants for the memory-dump UART.
package mem_dump_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_e;

    localparam logic [7:0] HEADER      = 8'hA5;
    localparam int         NBYTES      = 20;
    localparam int         FRAME_BYTES = 22;
    localparam int         IDX_W       = $clog2(FRAME_BYTES);

endpackage

// File: rtl/mem_dump_uart_tx_byte.sv
// 8N1 byte serializer with load/ready handshake. Owns the baud and bit counters.
module uart_tx_byte
    import mem_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (baud_q == CW'(CLKS_PER_BIT - 1));
    // Ready on the last cycle of the stop bit so the next byte follows with no gap.
    assign ready   = (state_q == IDLE) || ((state_q == STOP_BIT) && bit_end);
    assign tx      = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (load) begin
                    state_d = START_BIT;
                    bit_d   = '0;
                    sh_d    = data;
                    tx_d    = 1'b0;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_d = DATA_BITS;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP_BIT;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    if (load) begin
                        state_d = START_BIT;
                        bit_d   = '0;
                        sh_d    = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/mem_dump_uart.sv
// Snapshots mem8..mem27 on start and sends header, 20 data bytes and checksum over UART.
module mem_dump_uart
    import mem_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] mem8,  input logic [7:0] mem9,  input logic [7:0] mem10,
    input  logic [7:0] mem11, input logic [7:0] mem12, input logic [7:0] mem13,
    input  logic [7:0] mem14, input logic [7:0] mem15, input logic [7:0] mem16,
    input  logic [7:0] mem17, input logic [7:0] mem18, input logic [7:0] mem19,
    input  logic [7:0] mem20, input logic [7:0] mem21, input logic [7:0] mem22,
    input  logic [7:0] mem23, input logic [7:0] mem24, input logic [7:0] mem25,
    input  logic [7:0] mem26, input logic [7:0] mem27,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    logic [7:0]       mem_in   [NBYTES];
    logic [7:0]       shadow_q [NBYTES];
    logic [7:0]       shadow_d [NBYTES];
    logic [7:0]       csum_q, csum_d, csum_in;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept, load, ready;
    logic [7:0]       load_data;

    assign mem_in = '{mem8,  mem9,  mem10, mem11, mem12, mem13, mem14,
                      mem15, mem16, mem17, mem18, mem19, mem20, mem21,
                      mem22, mem23, mem24, mem25, mem26, mem27};

    // Sum the live inputs so the checksum lands in the same edge as the snapshot.
    always_comb begin
        csum_in = '0;
        for (int i = 0; i < NBYTES; i++) csum_in = csum_in + mem_in[i];
    end

    assign accept = start && !busy_q;

    always_comb begin
        shadow_d   = shadow_q;
        csum_d     = csum_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;
        load_data  = HEADER;
        if (accept) begin
            shadow_d   = mem_in;
            csum_d     = csum_in;
            byte_idx_d = '0;
            busy_d     = 1'b1;
            load       = 1'b1;
        end else if (busy_q && ready) begin
            if (byte_idx_q < IDX_W'(FRAME_BYTES - 1)) begin
                byte_idx_d = byte_idx_q + IDX_W'(1);
                load       = 1'b1;
                // Byte k+1 of the frame is shadow[k]; the last one is the checksum.
                load_data  = (byte_idx_q == IDX_W'(FRAME_BYTES - 2)) ? csum_q
                                                                      : shadow_q[byte_idx_q];
            end else begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= '{default: '0};
            csum_q     <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (load_data),
        .ready (ready),
        .tx    (tx)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/mem_dump_uart.md
# mem_dump_uart

Serial debug port that consumes the twenty memory-mapped output bytes mem8–mem27 produced by the CPU data memory. On a start request it snapshots all twenty bytes and transmits them as one framed 8N1 UART packet with a header byte and a checksum. It sits directly downstream of the CPU top level and lets a host read program results over one pin while the CPU keeps running.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit. Must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  frame request, sampled each cycle
- mem8 … mem27  input  8 each  memory-mapped output bytes from data memory
- tx  output  1  UART line, idle high
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse when a frame completes

## Operation
- Frame is 22 bytes, in this order:
  - header 8'hA5
  - mem8, mem9, …, mem27
  - checksum = 8-bit sum of the 20 data bytes mod 256. The header is not included.
- Each byte is sent 8N1: start bit 0, data bits LSB first, stop bit 1. Each bit is held CLKS_PER_BIT cycles.
- Snapshot rule:
  - On an accepted start, all 20 inputs are captured into shadow registers in the same edge.
  - The checksum is computed from the shadow copy.
  - Input changes during a frame never affect it.
- Accepting start:
  - start is accepted only when busy = 0.
  - start while busy is ignored. It is not queued.
- State machine:
  - IDLE → START_BIT on accepted start.
  - START_BIT → DATA_BITS after CLKS_PER_BIT cycles.
  - DATA_BITS → STOP_BIT after 8 bits.
  - STOP_BIT → START_BIT if byte_idx < 21. Otherwise STOP_BIT → IDLE and done is pulsed.
- Counters:
  - baud counter 0..CLKS_PER_BIT-1
  - bit_idx 0..7
  - byte_idx 0..21
  - All counters clear on entering START_BIT from IDLE.
- Reset values: tx = 1, busy = 0, done = 0, state IDLE, all counters 0, shadow registers 0.
- Reset mid-frame:
  - Abort immediately. tx = 1 the cycle after the reset edge.
  - No done pulse.
  - A later start sends a complete fresh frame.

## Timing
- tx, busy and done are registered outputs.
- Let start be sampled high at edge E0:
  - From E0, tx = 0 (start bit of the header) and busy = 1.
  - The whole frame occupies exactly 220·CLKS_PER_BIT cycles.
  - At edge E0 + 220·CLKS_PER_BIT: state = IDLE, busy = 0, done = 1 for exactly one cycle, tx = 1.
- start high during the done cycle is accepted, because busy = 0 then. The next frame begins at that edge with no idle gap.
- Bit boundaries land exactly on multiples of CLKS_PER_BIT from E0. There is no drift across bytes.
- Simultaneous rst and start: rst wins and the frame is not started.

## Structure
- Shared package (mem_dump_pkg):
  - state enum: IDLE, START_BIT, DATA_BITS, STOP_BIT
  - HEADER = 8'hA5
  - NBYTES = 20
  - FRAME_BYTES = 22
- Sub-module uart_tx_byte is the natural split:
  - It serializes one byte with load/ready handshake and owns the baud and bit counters.
  - mem_dump_uart keeps the snapshot, checksum, byte sequencing and done/busy.
- Checksum accumulates as the snapshot is taken, as a combinational adder tree over the inputs registered at capture. It is ready before the first data byte is needed.

## Test plan
- Reset:
  - Hold rst 3 cycles → tx = 1, busy = 0, done = 0 throughout.
  - No activity for 100 cycles after release.
- Nominal frame:
  - Setup: CLKS_PER_BIT = 4, mem8..mem27 = 8'h01..8'h14, start pulse.
  - Decoded bytes: A5, 01…14, D2.
  - done pulses at E0 + 880. busy is high for exactly 880 cycles.
- Snapshot:
  - Same setup, then change all mem inputs to 8'h55 one cycle after start.
  - Transmitted data are still 01…14 with checksum D2.
- Checksum wrap:
  - All mem inputs = 8'hFF → data bytes FF ×20, checksum 8'hEC.
- Start collisions:
  - Extra start pulses mid-frame → ignored, frame length still 880, exactly one done.
  - start asserted in the done cycle → second frame begins at that edge.
- Reset mid-frame:
  - Assert rst during byte 5 → tx = 1 and busy = 0 the next cycle, no done pulse.
  - A subsequent start yields a full, correct 22-byte frame.
